// File: rtl/detector_1010.sv
// Serial "1010" pattern detector: Moore FSM with a registered one-cycle detect
// flag and a saturating match counter, all cleared by a synchronous active-low clear.
module detector_1010 #(
    parameter bit          OVERLAP = 1'b1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             out_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Next-state decode; the trailing "10" of a match is reused only when OVERLAP is set.
    always_comb begin
        state_d = S0;
        case (state_q)
            S0: begin
                if (in) state_d = S1;
                else    state_d = S0;
            end
            S1: begin
                if (in) state_d = S1;
                else    state_d = S2;
            end
            S2: begin
                if (in) state_d = S3;
                else    state_d = S0;
            end
            S3: begin
                if (in) state_d = S1;
                else    state_d = S4;
            end
            S4: begin
                if (in) begin
                    if (OVERLAP) state_d = S3;
                    else         state_d = S1;
                end else begin
                    state_d = S0;
                end
            end
            default: state_d = S0;
        endcase
    end

    // Counter bumps on the same edge that moves the FSM into the match state.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d == S4) begin
            cnt_d = sat_inc(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, detect flag and counter registers; clear overrides everything.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= S0;
            out_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            out_q   <= (state_d == S4);
            cnt_q   <= cnt_d;
        end
    end

    assign out       = out_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_detector_1010.sv
// Scoreboard bench for detector_1010: three instances (overlap, non-overlap,
// 2-bit saturating counter) share one stimulus stream checked against a window model.
module tb_detector_1010;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       in  = 1'b0;
    logic       out_ov, out_no, out_sat;
    logic [7:0] cnt_ov, cnt_no;
    logic [1:0] cnt_sat;

    int checks   = 0;
    int failures = 0;

    logic [20:0] sb[$];

    logic [3:0] m_hist;
    int         m_nbits;
    int         m_since_no;
    logic [7:0] m_cov, m_cno;
    logic [1:0] m_csat;

    always #5 clk = ~clk;

    detector_1010 #(.OVERLAP(1'b1), .CNT_W(8)) dut_ov (
        .clk(clk), .clr(clr), .in(in), .out(out_ov), .match_cnt(cnt_ov));
    detector_1010 #(.OVERLAP(1'b0), .CNT_W(8)) dut_no (
        .clk(clk), .clr(clr), .in(in), .out(out_no), .match_cnt(cnt_no));
    detector_1010 #(.OVERLAP(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .clr(clr), .in(in), .out(out_sat), .match_cnt(cnt_sat));

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one bit, advance the reference window model, push expectation, wait for the edge.
    task automatic drive(input logic b, input logic c);
        logic mo, mn;
        @(negedge clk);
        in  = b;
        clr = c;
        mo  = 1'b0;
        mn  = 1'b0;
        if (!c) begin
            m_hist = 4'b0000; m_nbits = 0; m_since_no = 0;
            m_cov = 8'd0; m_cno = 8'd0; m_csat = 2'd0;
        end else begin
            m_hist = {m_hist[2:0], b};
            m_nbits++;
            m_since_no++;
            mo = (m_nbits >= 4) && (m_hist == 4'b1010);
            mn = mo && (m_since_no >= 4);
            if (mn) m_since_no = 0;
            if (mo) begin
                if (m_cov != 8'hFF) m_cov = m_cov + 8'd1;
                if (m_csat != 2'd3) m_csat = m_csat + 2'd1;
            end
            if (mn && m_cno != 8'hFF) m_cno = m_cno + 8'd1;
        end
        sb.push_back({mo, mn, mo, m_cov, m_cno, m_csat});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [20:0] exp, act;
        drive(1'b1, 1'b0);
        exp = sb.pop_front();
        act = {out_ov, out_no, out_sat, cnt_ov, cnt_no, cnt_sat};
        checks++;
        if (act !== exp || act !== 21'd0) begin
            failures++;
            $display("FAIL reset: got %h expected %h", act, exp);
        end
    endtask

    task automatic test_basic();
        logic [20:0] exp, act;
        logic [3:0]  pat;
        pat = 4'b1010;
        for (int i = 3; i >= 0; i--) begin
            drive(pat[i], 1'b1);
            exp = sb.pop_front();
            act = {out_ov, out_no, out_sat, cnt_ov, cnt_no, cnt_sat};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL basic bit %0d: got %h expected %h", 4 - i, act, exp);
            end
        end
        checks++;
        if (out_ov !== 1'b1 || cnt_ov !== 8'd1) begin
            failures++;
            $display("FAIL basic_final: got out=%b cnt=%0d expected out=1 cnt=1", out_ov, cnt_ov);
        end
    endtask

    task automatic test_stream();
        logic [20:0] exp, act;
        logic [17:0] pat;
        drive(1'b0, 1'b0);
        void'(sb.pop_front());
        pat = 18'b101010111010111010;
        for (int i = 17; i >= 0; i--) begin
            drive(pat[i], 1'b1);
            exp = sb.pop_front();
            act = {out_ov, out_no, out_sat, cnt_ov, cnt_no, cnt_sat};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL stream bit %0d: got %h expected %h", 18 - i, act, exp);
            end
        end
        checks++;
        if (cnt_ov !== 8'd4 || cnt_no !== 8'd3) begin
            failures++;
            $display("FAIL stream_counts: got ov=%0d no=%0d expected ov=4 no=3", cnt_ov, cnt_no);
        end
    endtask

    task automatic test_near_miss();
        logic [20:0] exp, act;
        logic [4:0]  pats[4];
        int          lens[4];
        logic [4:0]  p;
        int          pulses;
        pats = '{5'b01100, 5'b10010, 5'b01011, 5'b11010};
        lens = '{4, 5, 5, 5};
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0);
            void'(sb.pop_front());
            p      = pats[k];
            pulses = 0;
            for (int i = lens[k] - 1; i >= 0; i--) begin
                drive(p[i], 1'b1);
                exp = sb.pop_front();
                act = {out_ov, out_no, out_sat, cnt_ov, cnt_no, cnt_sat};
                if (out_ov === 1'b1) pulses++;
                checks++;
                if (act !== exp) begin
                    failures++;
                    $display("FAIL near_miss seq %0d bit %0d: got %h expected %h", k, lens[k] - i, act, exp);
                end
            end
            checks++;
            if (pulses != ((k == 3) ? 1 : 0)) begin
                failures++;
                $display("FAIL near_miss_pulses seq %0d: got %0d expected %0d", k, pulses, (k == 3) ? 1 : 0);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [20:0] exp, act;
        logic [4:0]  bits, clrs;
        drive(1'b0, 1'b0);
        void'(sb.pop_front());
        bits = 5'b10100;
        clrs = 5'b11101;
        for (int i = 4; i >= 0; i--) begin
            drive(bits[i], clrs[i]);
            exp = sb.pop_front();
            act = {out_ov, out_no, out_sat, cnt_ov, cnt_no, cnt_sat};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL reset_mid step %0d: got %h expected %h", 5 - i, act, exp);
            end
        end
        checks++;
        if (cnt_ov !== 8'd0 || out_ov !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_final: got out=%b cnt=%0d expected out=0 cnt=0", out_ov, cnt_ov);
        end
    endtask

    task automatic test_saturation();
        logic [20:0] exp, act;
        logic [11:0] pat;
        drive(1'b0, 1'b0);
        void'(sb.pop_front());
        pat = 12'b101010101010;
        for (int i = 11; i >= 0; i--) begin
            drive(pat[i], 1'b1);
            exp = sb.pop_front();
            act = {out_ov, out_no, out_sat, cnt_ov, cnt_no, cnt_sat};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL saturation bit %0d: got %h expected %h", 12 - i, act, exp);
            end
        end
        checks++;
        if (cnt_sat !== 2'd3 || cnt_ov !== 8'd5) begin
            failures++;
            $display("FAIL saturation_final: got sat=%0d ov=%0d expected sat=3 ov=5", cnt_sat, cnt_ov);
        end
    endtask

    task automatic test_back_to_back();
        logic [20:0] exp, act;
        logic        prev_out;
        drive(1'b0, 1'b0);
        void'(sb.pop_front());
        prev_out = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(1, 0)), 1'b1);
            exp = sb.pop_front();
            act = {out_ov, out_no, out_sat, cnt_ov, cnt_no, cnt_sat};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL random bit %0d: got %h expected %h", i, act, exp);
            end
            checks++;
            if (prev_out === 1'b1 && out_ov === 1'b1) begin
                failures++;
                $display("FAIL pulse_width bit %0d: got out high twice expected single cycle", i);
            end
            prev_out = out_ov;
        end
    endtask

    initial begin
        m_hist = 4'b0000; m_nbits = 0; m_since_no = 0;
        m_cov = 8'd0; m_cno = 8'd0; m_csat = 2'd0;
        test_reset();
        test_basic();
        test_stream();
        test_near_miss();
        test_reset_mid();
        test_saturation();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
